// File: rtl/sync_pkg.sv
// Shared state encoding for the debounce/qualification FSM.
package sync_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    LOW_QUAL    = 2'd1,
    HIGH_STABLE = 2'd2,
    HIGH_QUAL   = 2'd3
  } state_t;

endpackage

// File: rtl/edge_detect.sv
// One-cycle rise/fall pulses from a level, registered on the level's previous value.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/debounce_edge.sv
// Debouncer: accepts a level change after STABLE_CYCLES consecutive enabled differing samples.
// Optional accepted-change counter evt_cnt is built only with DEBOUNCE_EVT_CNT_EN defined.
module debounce_edge
  import sync_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sync_in,
  output logic                 level,
  output logic                 rise,
  output logic                 fall
`ifdef DEBOUNCE_EVT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] evt_cnt
`endif
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW_STABLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The sample that would bring cnt to STABLE_CYCLES switches state instead,
  // so cnt never holds STABLE_CYCLES and cannot wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (en) begin
      unique case (state)
        LOW_STABLE: begin
          if (sync_in) begin
            state_nxt = LOW_QUAL;
            cnt_nxt   = ONE;
          end
        end
        LOW_QUAL: begin
          if (!sync_in) begin
            state_nxt = LOW_STABLE;
            cnt_nxt   = '0;
          end else if (cnt == LAST) begin
            state_nxt = HIGH_STABLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
        HIGH_STABLE: begin
          if (!sync_in) begin
            state_nxt = HIGH_QUAL;
            cnt_nxt   = ONE;
          end
        end
        HIGH_QUAL: begin
          if (sync_in) begin
            state_nxt = HIGH_STABLE;
            cnt_nxt   = '0;
          end else if (cnt == LAST) begin
            state_nxt = LOW_STABLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
        default: begin
          state_nxt = LOW_STABLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign level = (state == HIGH_STABLE) || (state == HIGH_QUAL);

  edge_detect u_edge_detect (
    .clk   (clk),
    .rst   (rst),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

`ifdef DEBOUNCE_EVT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)              evt_cnt <= '0;
    else if (rise | fall) evt_cnt <= evt_cnt + ONE;
  end
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: directed scenarios plus random stimulus vs a run-length model.
module tb_debounce_edge;

`ifdef DEBOUNCE_EVT_CNT_EN
  localparam int unsigned SC = 3;
  localparam int unsigned CW = 2;
`else
  localparam int unsigned SC = 4;
  localparam int unsigned CW = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic sync_in = 1'b0;
  logic level, rise, fall;
`ifdef DEBOUNCE_EVT_CNT_EN
  logic [CW-1:0] evt_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference: expected level, length of the current enabled run differing from it, pulses, event count.
  bit          m_level = 1'b0;
  bit          m_rise  = 1'b0;
  bit          m_fall  = 1'b0;
  int unsigned m_run   = 0;
  int unsigned m_evt   = 0;

  always #5 clk = ~clk;

  debounce_edge #(
    .STABLE_CYCLES (SC),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync_in (sync_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
`ifdef DEBOUNCE_EVT_CNT_EN
    ,
    .evt_cnt (evt_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit e, input bit s);
    if (r) begin
      m_level = 1'b0;
      m_run   = 0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      m_evt   = 0;
    end else begin
      if (m_rise || m_fall) m_evt = (m_evt + 1) % (1 << CW);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (e) begin
        if (s != m_level) begin
          m_run++;
          if (m_run == SC) begin
            m_level = s;
            m_run   = 0;
            m_rise  = s;
            m_fall  = !s;
          end
        end else begin
          m_run = 0;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit s);
    rst     = r;
    en      = e;
    sync_in = s;
    @(posedge clk);
    model(r, e, s);
    #1;
    chk("level", level, m_level);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("rise_fall_excl", rise & fall, 0);
`ifdef DEBOUNCE_EVT_CNT_EN
    chk("evt_cnt", evt_cnt, m_evt);
`endif
  endtask

  initial begin
    bit cur;
    bit s;

    // Reset for two cycles
    cyc(1, 0, 0);
    cyc(1, 1, 1);
    chk("reset_level", level, 0);
    chk("reset_rise", rise, 0);
    chk("reset_fall", fall, 0);

    // Held 1 after reset is qualified normally: level/rise on the SC-th sampled 1
    for (int i = 0; i < SC - 1; i++) begin
      cyc(0, 1, 1);
      chk("qual_level_low", level, 0);
    end
    cyc(0, 1, 1);
    chk("accept_level", level, 1);
    chk("accept_rise", rise, 1);
    cyc(0, 1, 1);
    chk("rise_one_cycle", rise, 0);

    // Short low glitch from level=1 is rejected
    for (int i = 0; i < SC - 1; i++) cyc(0, 1, 0);
    cyc(0, 1, 1);
    chk("glitch_level", level, 1);
    chk("glitch_fall", fall, 0);
    cyc(0, 1, 1);

    // Full low run produces fall
    for (int i = 0; i < SC; i++) cyc(0, 1, 0);
    chk("accept_fall", fall, 1);
    chk("accept_level_low", level, 0);
    cyc(0, 1, 0);

    // Qualification pauses across en=0 and resumes without restarting
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1'($urandom_range(0, 1)));
      chk("hold_level", level, 0);
    end
    for (int i = 0; i < SC - 2; i++) cyc(0, 1, 1);
    chk("resume_level", level, 1);
    chk("resume_rise", rise, 1);

    // Mid-qualification reset discards progress
    for (int i = 0; i < SC + 1; i++) cyc(0, 1, 0);
    for (int i = 0; i < SC - 1; i++) cyc(0, 1, 1);
    cyc(1, 1, 1);
    chk("midrst_level", level, 0);
    chk("midrst_rise", rise, 0);
    for (int i = 0; i < SC; i++) cyc(0, 1, 1);
    chk("postrst_rise", rise, 1);

`ifdef DEBOUNCE_EVT_CNT_EN
    // Event counter wraps modulo 2^CW
    cyc(1, 0, 0);
    cur = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cur = ~cur;
      for (int i = 0; i < SC; i++) cyc(0, 1, cur);
      cyc(0, 1, cur);
      chk("evt_seq", evt_cnt, k % (1 << CW));
    end
`endif

    // Alternating toggle never qualifies
    cyc(1, 0, 0);
    for (int i = 0; i < 50; i++) begin
      cyc(0, 1, (i % 2) == 0);
      chk("toggle_level", level, 0);
      chk("toggle_rise", rise, 0);
    end

    // Random stimulus: slowly wandering target with glitches, en gaps and rare resets
    cur = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) cur = ~cur;
      s = ($urandom_range(0, 7) == 0) ? ~cur : cur;
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 9) != 0, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
